// File: rtl/countdown_timer.sv
// countdown_timer: loadable, prescaled down-counter with a registered expiry pulse
// and optional auto-reload. A four-state FSM handles load, start, pause/resume and expiry.
`default_nettype none

module countdown_timer #(
  parameter int N = 8,
  parameter int P = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         start,
  input  logic         pause,
  input  logic         reload_en,
  input  logic [P-1:0] presc,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         paused,
  output logic         expired,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] reload_q, reload_d;
  logic [P-1:0] psc_q, psc_d;
  logic         done_q, done_d;
  logic         tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      psc_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      psc_q    <= psc_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    psc_d    = psc_q;
    done_d   = 1'b0;
    tick     = (psc_q == presc);

    case (state_q)
      IDLE: begin
        if (load) begin
          count_d  = load_val;
          reload_d = load_val;
        end else if (start) begin
          if (count_q != '0) begin
            state_d = RUN;
            psc_d   = '0;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      RUN: begin
        // A coincident pause suppresses both the prescaler step and the tick.
        if (pause) begin
          state_d = PAUSE;
        end else if (tick) begin
          psc_d = '0;
          if (count_q == N'(1)) begin
            done_d = 1'b1;
            if (reload_en) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = DONE;
            end
          end else if (count_q != '0) begin
            count_d = count_q - N'(1);
          end
        end else begin
          psc_d = psc_q + P'(1);
        end
      end

      PAUSE: begin
        if (start) begin
          state_d = RUN;
        end
      end

      DONE: begin
        if (load) begin
          count_d  = load_val;
          reload_d = load_val;
          state_d  = IDLE;
        end else if (start) begin
          if (reload_q != '0) begin
            count_d = reload_q;
            psc_d   = '0;
            state_d = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign count   = count_q;
  assign done    = done_q;
  assign busy    = (state_q == RUN) || (state_q == PAUSE);
  assign paused  = (state_q == PAUSE);
  assign expired = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: each driven cycle pushes its expected outputs,
// a monitor pops and compares them just after the following rising edge.
`default_nettype none

module tb_countdown_timer;

  localparam int N = 8;
  localparam int P = 4;

  // Expected flag encoding: {busy, paused, expired, done}
  localparam logic [3:0] F_IDLE  = 4'b0000;
  localparam logic [3:0] F_RUN   = 4'b1000;
  localparam logic [3:0] F_PAUSE = 4'b1100;
  localparam logic [3:0] F_DONE  = 4'b0010;
  localparam logic [3:0] F_PULSE = 4'b0001;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         reload_en = 1'b0;
  logic [P-1:0] presc = '0;
  logic [N-1:0] count;
  logic         busy, paused, expired, done;

  typedef struct {
    string        tag;
    logic [N-1:0] count;
    logic [3:0]   flags;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   tests_run = 0;
  int   tests_failed = 0;

  countdown_timer #(.N(N), .P(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_val  (load_val),
    .start     (start),
    .pause     (pause),
    .reload_en (reload_en),
    .presc     (presc),
    .count     (count),
    .busy      (busy),
    .paused    (paused),
    .expired   (expired),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.tag, ".count"}, 32'(count), 32'(e.count));
      check({e.tag, ".flags"}, 32'({busy, paused, expired, done}), 32'(e.flags));
    end
  end

  // Drive one cycle of inputs and record what the outputs must be after the next edge.
  task automatic step(input string tag, input logic r, input logic l, input logic [N-1:0] lv,
                      input logic s, input logic pa, input logic re, input logic [P-1:0] pr,
                      input logic [N-1:0] ec, input logic [3:0] ef);
    exp_t x;
    @(negedge clk);
    rst = r; load = l; load_val = lv; start = s; pause = pa; reload_en = re; presc = pr;
    x.tag = tag; x.count = ec; x.flags = ef;
    sb.push_back(x);
  endtask

  initial begin
    // Reset, load, basic expiry with presc=0
    step("rst",    1, 0, 0, 0, 0, 0, 0, 0, F_IDLE);
    step("ld3",    0, 1, 3, 0, 0, 0, 0, 3, F_IDLE);
    step("st3",    0, 0, 0, 1, 0, 0, 0, 3, F_RUN);
    step("c2",     0, 0, 0, 0, 0, 0, 0, 2, F_RUN);
    step("c1",     0, 0, 0, 0, 0, 0, 0, 1, F_RUN);
    step("c0",     0, 0, 0, 0, 0, 0, 0, 0, F_DONE | F_PULSE);
    step("exp",    0, 0, 0, 0, 0, 0, 0, 0, F_DONE);

    // Prescaler: load 2 from DONE, presc=3, expiry 8 cycles into RUN
    step("ld2",    0, 1, 2, 0, 0, 0, 3, 2, F_IDLE);
    step("st2",    0, 0, 0, 1, 0, 0, 3, 2, F_RUN);
    for (int i = 1; i <= 8; i++) begin
      step($sformatf("psc%0d", i), 0, 0, 0, 0, 0, 0, 3,
           (i < 4) ? N'(2) : (i < 8) ? N'(1) : N'(0),
           (i == 8) ? (F_DONE | F_PULSE) : F_RUN);
    end

    // Pause/resume, pause coincident with a tick
    step("ld5",    0, 1, 5, 0, 0, 0, 0, 5, F_IDLE);
    step("st5",    0, 0, 0, 1, 0, 0, 0, 5, F_RUN);
    step("p4",     0, 0, 0, 0, 0, 0, 0, 4, F_RUN);
    step("p3",     0, 0, 0, 0, 0, 0, 0, 3, F_RUN);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("hold%0d", i), 0, (i == 2), 9, 0, 1, 0, 0, 3, F_PAUSE);
    end
    step("resume", 0, 0, 0, 1, 0, 0, 0, 3, F_RUN);
    step("r2",     0, 0, 0, 0, 0, 0, 0, 2, F_RUN);
    step("r1",     0, 0, 0, 0, 0, 0, 0, 1, F_RUN);
    step("r0",     0, 0, 0, 0, 0, 0, 0, 0, F_DONE | F_PULSE);

    // Auto-reload: 2,1,2,1,... with a done pulse each reload
    step("ldar",   0, 1, 2, 0, 0, 1, 0, 2, F_IDLE);
    step("star",   0, 0, 0, 1, 0, 1, 0, 2, F_RUN);
    for (int i = 1; i <= 8; i++) begin
      step($sformatf("ar%0d", i), 0, 0, 0, 0, 0, 1, 0,
           (i % 2 == 1) ? N'(1) : N'(2),
           (i % 2 == 0) ? (F_RUN | F_PULSE) : F_RUN);
    end
    // load and start in RUN are ignored
    step("ignrun", 0, 1, 9, 1, 0, 1, 0, 1, F_RUN);
    step("arend", 0, 0, 0, 0, 0, 0, 0, 0, F_DONE | F_PULSE);

    // load+start together in IDLE: load wins; then restart from DONE with reload=4
    step("ld4",    0, 1, 4, 0, 0, 0, 0, 4, F_IDLE);
    step("ldst",   0, 1, 4, 1, 0, 0, 0, 4, F_IDLE);
    step("st4",    0, 0, 0, 1, 0, 0, 0, 4, F_RUN);
    step("d3",     0, 0, 0, 0, 0, 0, 0, 3, F_RUN);
    step("d2",     0, 0, 0, 0, 0, 0, 0, 2, F_RUN);
    step("d1",     0, 0, 0, 0, 0, 0, 0, 1, F_RUN);
    step("d0",     0, 0, 0, 0, 0, 0, 0, 0, F_DONE | F_PULSE);
    step("rest4",  0, 0, 0, 1, 0, 0, 0, 4, F_RUN);
    step("rs3",    0, 0, 0, 0, 0, 0, 0, 3, F_RUN);

    // Reset mid-RUN at count 6 of a 10-count
    step("rst2",   1, 0, 0, 0, 0, 0, 0, 0, F_IDLE);
    step("ld10",   0, 1, 10, 0, 0, 0, 0, 10, F_IDLE);
    step("st10",   0, 0, 0, 1, 0, 0, 0, 10, F_RUN);
    step("m9",     0, 0, 0, 0, 0, 0, 0, 9, F_RUN);
    step("m8",     0, 0, 0, 0, 0, 0, 0, 8, F_RUN);
    step("m7",     0, 0, 0, 0, 0, 0, 0, 7, F_RUN);
    step("m6",     0, 0, 0, 0, 0, 0, 0, 6, F_RUN);
    step("rstmid", 1, 0, 0, 1, 0, 0, 0, 0, F_IDLE);
    // Start with count=0, then start in DONE with the cleared reload register
    step("st0",    0, 0, 0, 1, 0, 1, 0, 0, F_DONE | F_PULSE);
    step("dst0",   0, 0, 0, 1, 0, 0, 0, 0, F_DONE | F_PULSE);
    step("dhold",  0, 0, 0, 0, 0, 0, 0, 0, F_DONE);

    @(posedge clk);
    #3;
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
